// File: rtl/sad_search_unit.sv
`default_nettype none
// ============================================================================
// Module   : sad_search_unit
// Purpose  : Full-search sum-of-absolute-differences motion-estimation engine.
//            Scans every block-sized candidate position of the reference frame
//            in raster order, accumulating |frame - window| over a 4/8/16 wide
//            and high block. It reports the minimum SAD and where it was found,
//            then pulses `complete` to release the instruction pipeline stall.
// Ports    : Clk/Rst_n    - clock, asynchronous active-low reset
//            start        - begin a search (ignored while busy)
//            blk_w/blk_h  - block dimensions, sampled on an accepted start
//            rd_en        - read request, held until rd_valid
//            frm_addr     - frame pixel address (row-major, FRAME_W per row)
//            win_addr     - window pixel address (WIN_STRIDE per row)
//            rd_valid     - read data valid; frm_pix/win_pix carry the data
//            busy         - search in progress
//            complete     - one-cycle done pulse
//            err          - last request had illegal dimensions
//            best_sad/x/y - minimum SAD and its candidate position
// Revision : 1.0 - initial release
// ============================================================================
module sad_search_unit #(
    parameter int FRAME_W    = 64,
    parameter int FRAME_H    = 64,
    parameter int PIX_W      = 8,
    parameter int WIN_STRIDE = 16,
    localparam int XW = $clog2(FRAME_W),
    localparam int YW = $clog2(FRAME_H),
    localparam int AW = $clog2(FRAME_W * FRAME_H)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic [4:0]       blk_w,
    input  logic [4:0]       blk_h,
    output logic             rd_en,
    output logic [AW-1:0]    frm_addr,
    output logic [7:0]       win_addr,
    input  logic             rd_valid,
    input  logic [PIX_W-1:0] frm_pix,
    input  logic [PIX_W-1:0] win_pix,
    output logic             busy,
    output logic             complete,
    output logic             err,
    output logic [15:0]      best_sad,
    output logic [XW-1:0]    best_x,
    output logic [YW-1:0]    best_y
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [4:0]      r_bw, r_bh;
    logic [4:0]      r_i, r_j, w_i_nxt, w_j_nxt;
    logic [XW-1:0]   r_cx, w_cx_nxt, w_cx_last;
    logic [YW-1:0]   r_cy, w_cy_nxt, w_cy_last;
    logic [15:0]     r_acc;
    logic            w_dims_ok;
    logic [PIX_W:0]  w_diff;
    logic [YW-1:0]   w_row;
    logic [XW-1:0]   w_col;

    assign w_dims_ok = ((r_bw == 5'd4) || (r_bw == 5'd8) || (r_bw == 5'd16)) &&
                       ((r_bh == 5'd4) || (r_bh == 5'd8) || (r_bh == 5'd16));

    // Last legal candidate origin keeps the block inside the frame.
    assign w_cx_last = XW'(FRAME_W - int'(r_bw));
    assign w_cy_last = YW'(FRAME_H - int'(r_bh));

    assign w_diff = (frm_pix >= win_pix) ? ({1'b0, frm_pix} - {1'b0, win_pix})
                                         : ({1'b0, win_pix} - {1'b0, frm_pix});

    // Addresses are registered, so they are computed from the index values the
    // FSM will hold in the FETCH cycle being entered.
    assign w_row = w_cy_nxt + YW'(w_j_nxt);
    assign w_col = w_cx_nxt + XW'(w_i_nxt);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_i_nxt     = '0;
                w_j_nxt     = '0;
                w_cx_nxt    = '0;
                w_cy_nxt    = '0;
                w_state_nxt = w_dims_ok ? S_FETCH : S_DONE;
            end
            S_FETCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (rd_valid) begin
                    if (r_i == r_bw - 5'd1) begin
                        w_i_nxt = '0;
                        if (r_j == r_bh - 5'd1) begin
                            w_j_nxt     = '0;
                            w_state_nxt = S_NEXT;
                        end else begin
                            w_j_nxt     = r_j + 5'd1;
                            w_state_nxt = S_FETCH;
                        end
                    end else begin
                        w_i_nxt     = r_i + 5'd1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_NEXT: begin
                if (r_cx == w_cx_last) begin
                    w_cx_nxt = '0;
                    if (r_cy == w_cy_last) begin
                        w_cy_nxt    = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cy_nxt    = r_cy + YW'(1);
                        w_state_nxt = S_FETCH;
                    end
                end else begin
                    w_cx_nxt    = r_cx + XW'(1);
                    w_state_nxt = S_FETCH;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_bw     <= '0;
            r_bh     <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_acc    <= '0;
            rd_en    <= 1'b0;
            frm_addr <= '0;
            win_addr <= '0;
            busy     <= 1'b0;
            complete <= 1'b0;
            err      <= 1'b0;
            best_sad <= 16'hFFFF;
            best_x   <= '0;
            best_y   <= '0;
        end else begin
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_cx     <= w_cx_nxt;
            r_cy     <= w_cy_nxt;
            // Outputs derived from the next state so they line up with it.
            rd_en    <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_WAIT);
            busy     <= (w_state_nxt != S_IDLE);
            complete <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_FETCH) begin
                frm_addr <= AW'({w_row, w_col});
                win_addr <= 8'(32'(w_j_nxt) * WIN_STRIDE + 32'(w_i_nxt));
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bw <= blk_w;
                        r_bh <= blk_h;
                    end
                end
                S_LOAD: begin
                    r_acc    <= '0;
                    err      <= ~w_dims_ok;
                    best_sad <= 16'hFFFF;
                    best_x   <= '0;
                    best_y   <= '0;
                end
                S_WAIT: begin
                    if (rd_valid) begin
                        r_acc <= r_acc + 16'(w_diff);
                    end
                end
                S_NEXT: begin
                    // Strict compare keeps the earliest candidate on a tie.
                    if (r_acc < best_sad) begin
                        best_sad <= r_acc;
                        best_x   <= r_cx;
                        best_y   <= r_cy;
                    end
                    r_acc <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sad_search_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_search_unit
// Purpose  : Self-checking bench for sad_search_unit on a 16x16 frame, with a
//            behavioural memory responder and a plain-loop full-search model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sad_search_unit;

    localparam int FW     = 16;
    localparam int FH     = 16;
    localparam int BUDGET = 60000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  blk_w, blk_h;
    logic        rd_en;
    logic [7:0]  frm_addr;
    logic [7:0]  win_addr;
    logic        rd_valid;
    logic [7:0]  frm_pix, win_pix;
    logic        busy, complete, err;
    logic [15:0] best_sad;
    logic [3:0]  best_x, best_y;

    logic [7:0]  frm_mem [0:255];
    logic [7:0]  win_mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;
    int cmpl_cnt = 0;
    int rden_cnt = 0;
    int lat_cur;
    int lat_cnt;
    bit rand_lat = 1'b0;

    sad_search_unit #(
        .FRAME_W   (FW),
        .FRAME_H   (FH),
        .PIX_W     (8),
        .WIN_STRIDE(16)
    ) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .start    (start),
        .blk_w    (blk_w),
        .blk_h    (blk_h),
        .rd_en    (rd_en),
        .frm_addr (frm_addr),
        .win_addr (win_addr),
        .rd_valid (rd_valid),
        .frm_pix  (frm_pix),
        .win_pix  (win_pix),
        .busy     (busy),
        .complete (complete),
        .err      (err),
        .best_sad (best_sad),
        .best_x   (best_x),
        .best_y   (best_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (complete) cmpl_cnt <= cmpl_cnt + 1;
        if (rd_en)    rden_cnt <= rden_cnt + 1;
    end

    // Memory: answers a held request after lat_cur cycles, one at a time.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            lat_cnt  <= 0;
            lat_cur  <= 1;
            frm_pix  <= '0;
            win_pix  <= '0;
        end else if (rd_valid) begin
            rd_valid <= 1'b0;
            lat_cnt  <= 0;
            lat_cur  <= rand_lat ? int'($urandom_range(1, 4)) : 1;
        end else if (rd_en) begin
            if (lat_cnt + 1 >= lat_cur) begin
                rd_valid <= 1'b1;
                frm_pix  <= frm_mem[frm_addr];
                win_pix  <= win_mem[win_addr];
            end
            lat_cnt <= lat_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Exhaustive raster-order search; strict less-than keeps the first minimum.
    function automatic void ref_search(input int bw, input int bh,
                                       output int sad, output int bx, output int by);
        sad = 65535; bx = 0; by = 0;
        for (int cy = 0; cy <= FH - bh; cy++) begin
            for (int cx = 0; cx <= FW - bw; cx++) begin
                int s;
                s = 0;
                for (int j = 0; j < bh; j++) begin
                    for (int i = 0; i < bw; i++) begin
                        int d;
                        d = int'(frm_mem[(cy + j) * FW + cx + i]) - int'(win_mem[j * 16 + i]);
                        s += (d < 0) ? -d : d;
                    end
                end
                if (s < sad) begin
                    sad = s; bx = cx; by = cy;
                end
            end
        end
    endfunction

    // Launches a search and waits for complete; optionally pulses a second
    // start (with other dimensions) at cycle inject_at of the search.
    task automatic run(input int bw, input int bh, input int inject_at,
                       output int lat, output int first_rd, output int busy1);
        @(negedge clk);
        start = 1'b1; blk_w = 5'(bw); blk_h = 5'(bh);
        lat = -1; first_rd = -1; busy1 = 0;
        for (int n = 1; n <= BUDGET; n++) begin
            @(negedge clk);
            start = (n == inject_at);
            if (n == inject_at) begin
                blk_w = 5'd8; blk_h = 5'd8;
            end
            if (n == 1) busy1 = int'(busy);
            if (rd_en && first_rd < 0) first_rd = n;
            if (complete) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic verify(input string tag, input int bw, input int bh, input bit fixed_lat,
                          input int inject_at);
        int lat, first_rd, busy1, c0, esad, ex, ey;
        c0 = cmpl_cnt;
        run(bw, bh, inject_at, lat, first_rd, busy1);
        ref_search(bw, bh, esad, ex, ey);
        check({tag, "_done"}, 32'(lat > 0), 32'd1);
        check({tag, "_busy_rise"}, 32'(busy1), 32'd1);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        check({tag, "_sad"}, 32'(best_sad), 32'(esad));
        check({tag, "_x"}, 32'(best_x), 32'(ex));
        check({tag, "_y"}, 32'(best_y), 32'(ey));
        check({tag, "_err"}, 32'(err), 32'd0);
        if (fixed_lat) begin
            check({tag, "_first_rd"}, 32'(first_rd), 32'd2);
            check({tag, "_latency"}, 32'(lat),
                  32'(2 + (FW - bw + 1) * (FH - bh + 1) * (bw * bh * 2 + 1)));
        end
        @(negedge clk);
        check({tag, "_pulse_1cyc"}, 32'(complete), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        check({tag, "_pulses"}, 32'(cmpl_cnt - c0), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_sad_held"}, 32'(best_sad), 32'(esad));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_complete"}, 32'(complete), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_frm_addr"}, 32'(frm_addr), 32'd0);
        check({tag, "_win_addr"}, 32'(win_addr), 32'd0);
        check({tag, "_best_sad"}, 32'(best_sad), 32'hFFFF);
        check({tag, "_best_xy"}, 32'({best_x, best_y}), 32'd0);
    endtask

    initial begin
        int lat, first_rd, busy1, c0, r0, guard;
        rst_n = 1'b0; start = 1'b0; blk_w = 5'd4; blk_h = 5'd4;
        for (int k = 0; k < 256; k++) begin
            frm_mem[k] = 8'd0; win_mem[k] = 8'd0;
        end
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero frame and window: every candidate ties, first one wins.
        verify("zero4x4", 4, 4, 1'b1, 0);

        // Random frame with the 8x8 window planted at (5,7).
        for (int k = 0; k < 256; k++) begin
            frm_mem[k] = 8'($urandom); win_mem[k] = 8'($urandom);
        end
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < 8; i++)
                frm_mem[(7 + j) * FW + 5 + i] = win_mem[j * 16 + i];
        verify("plant8x8", 8, 8, 1'b1, 0);
        check("plant_pos", 32'({best_x, best_y}), 32'({4'd5, 4'd7}));

        // Maximum accumulation on a single 16x16 candidate.
        for (int k = 0; k < 256; k++) begin
            frm_mem[k] = 8'd255; win_mem[k] = 8'd0;
        end
        verify("max16x16", 16, 16, 1'b1, 0);
        check("max_sad_const", 32'(best_sad), 32'd65280);

        // Illegal width: LOAD then DONE, no reads.
        r0 = rden_cnt; c0 = cmpl_cnt;
        run(3, 8, 0, lat, first_rd, busy1);
        check("illegal_latency", 32'(lat), 32'd2);
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_sad", 32'(best_sad), 32'hFFFF);
        check("illegal_xy", 32'({best_x, best_y}), 32'd0);
        @(negedge clk);
        check("illegal_no_rd", 32'(rden_cnt - r0), 32'd0);
        check("illegal_pulses", 32'(cmpl_cnt - c0), 32'd1);

        // Second start during a running search must not disturb it.
        for (int k = 0; k < 256; k++) begin
            frm_mem[k] = 8'($urandom); win_mem[k] = 8'($urandom);
        end
        verify("dblstart", 4, 4, 1'b1, 10);

        // Reset in the middle of a WAIT, then a fresh search with random L.
        rand_lat = 1'b1;
        for (int k = 0; k < 256; k++) begin
            frm_mem[k] = 8'($urandom_range(0, 40)); win_mem[k] = 8'($urandom_range(0, 40));
        end
        @(negedge clk);
        start = 1'b1; blk_w = 5'd4; blk_h = 5'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        guard = 0;
        while (!(rd_en && !rd_valid && lat_cnt >= 1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("reach_wait", 32'(guard < 200), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        check("midreset_held_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        verify("after_rst", 4, 8, 1'b0, 0);

        // Wide-short block with random latency.
        verify("rand16x4", 16, 4, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
